// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: FSM state encoding and
// instruction field positions.
package decode_pkg;

    // Decode FSM: S_IDLE decodes fresh instructions, S_IMM waits for the
    // immediate word that follows a two-word instruction.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_IMM  = 1'b1
    } dec_state_e;

    // Instruction word width and field bit positions (LSB of each field).
    localparam int INSTR_W   = 16;
    localparam int SRC1_LSB  = 8;   // src1 and dst share bits [10:8]
    localparam int SRC2_LSB  = 5;   // src2 in bits [7:5]
    localparam int SHAMT_LSB = 0;   // shift amount in bits [3:0]
    localparam int SHAMT_W   = 4;

endpackage : decode_pkg

// File: rtl/param_reg_file.sv
// Register file for the decode stage: N_REGS x WIDTH, two combinational
// read ports, one write port committed on the clock edge.
// Build option: DECODE_WB_BYPASS_EN forwards same-cycle write data to the
// read ports; without it a read returns the value held before the write.
module param_reg_file #(
    parameter  int WIDTH  = 16,
    parameter  int N_REGS = 8,
    localparam int ADDR_W = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2
);

    logic [WIDTH-1:0] regs_r [N_REGS];
    logic [WIDTH-1:0] rd1_raw_s;
    logic [WIDTH-1:0] rd2_raw_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;

    // Storage: clear on reset, otherwise commit the write-back port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && (int'(waddr) < N_REGS)) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Raw array reads; addresses beyond N_REGS read as zero.
    always_comb begin
        rd1_raw_s = '0;
        rd2_raw_s = '0;
        if (int'(raddr1) < N_REGS) begin
            rd1_raw_s = regs_r[raddr1];
        end else begin
            rd1_raw_s = '0;
        end
        if (int'(raddr2) < N_REGS) begin
            rd2_raw_s = regs_r[raddr2];
        end else begin
            rd2_raw_s = '0;
        end
    end

    // Read ports, optionally forwarding the in-flight write.
    always_comb begin
        rd1_s = rd1_raw_s;
        rd2_s = rd2_raw_s;
`ifdef DECODE_WB_BYPASS_EN
        if (we && (waddr == raddr1)) begin
            rd1_s = wdata;
        end else begin
            rd1_s = rd1_raw_s;
        end
        if (we && (waddr == raddr2)) begin
            rd2_s = wdata;
        end else begin
            rd2_s = rd2_raw_s;
        end
`else
        rd1_s = rd1_raw_s;
        rd2_s = rd2_raw_s;
`endif
    end

    assign rdata1 = rd1_s;
    assign rdata2 = rd2_s;

endmodule : param_reg_file

// File: rtl/param_decode_stage.sv
// Instruction decode stage: field extraction, register read, load-use
// hazard detection, two-word (immediate) instruction assembly and the
// ID/EX pipeline register.
// Build option: DECODE_WB_BYPASS_EN (see param_reg_file) enables
// write-back to read forwarding in the register file.
module param_decode_stage
    import decode_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int N_REGS = 8,
    parameter  int PC_W   = 32,
    parameter  int CTRL_W = 24,
    localparam int ADDR_W = $clog2(N_REGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [PC_W-1:0]    pc,
    input  logic [CTRL_W-1:0]  ctrl,
    input  logic               two_word,
    input  logic               wb_we,
    input  logic [ADDR_W-1:0]  wb_addr,
    input  logic [WIDTH-1:0]   wb_data,
    input  logic               ex_mem_read,
    input  logic [ADDR_W-1:0]  ex_rd,
    input  logic               flush,
    input  logic               ex_stall,
    output logic               stall_fetch,
    output logic               id_valid,
    output logic [CTRL_W-1:0]  id_ctrl,
    output logic [WIDTH-1:0]   id_src1_data,
    output logic [WIDTH-1:0]   id_src2_data,
    output logic [ADDR_W-1:0]  id_src1,
    output logic [ADDR_W-1:0]  id_src2,
    output logic [ADDR_W-1:0]  id_dst,
    output logic [PC_W-1:0]    id_pc,
    output logic [WIDTH-1:0]   id_imm,
    output logic [SHAMT_W-1:0] id_shamt
);

    // Fields of the word currently presented.
    logic [ADDR_W-1:0]  cur_src1_s;
    logic [ADDR_W-1:0]  cur_src2_s;
    logic [SHAMT_W-1:0] cur_shamt_s;
    logic [WIDTH-1:0]   imm_word_s;

    // FSM and the held first word of a two-word instruction.
    dec_state_e         state_r, state_next_s;
    logic [CTRL_W-1:0]  held_ctrl_r, held_ctrl_s;
    logic [PC_W-1:0]    held_pc_r, held_pc_s;
    logic [ADDR_W-1:0]  held_src1_r, held_src1_s;
    logic [ADDR_W-1:0]  held_src2_r, held_src2_s;
    logic [SHAMT_W-1:0] held_shamt_r, held_shamt_s;

    // Register file read side.
    logic [ADDR_W-1:0]  rd1_addr_s;
    logic [ADDR_W-1:0]  rd2_addr_s;
    logic [WIDTH-1:0]   rd1_data_s;
    logic [WIDTH-1:0]   rd2_data_s;

    logic               hazard_s;

    // ID/EX register and its next value.
    logic               idv_r, idv_s;
    logic [CTRL_W-1:0]  ctrl_r, ctrl_s;
    logic [WIDTH-1:0]   s1d_r, s1d_s;
    logic [WIDTH-1:0]   s2d_r, s2d_s;
    logic [ADDR_W-1:0]  s1_r, s1_s;
    logic [ADDR_W-1:0]  s2_r, s2_s;
    logic [ADDR_W-1:0]  dst_r, dst_s;
    logic [PC_W-1:0]    pc_r, pc_s;
    logic [WIDTH-1:0]   imm_r, imm_s;
    logic [SHAMT_W-1:0] shamt_r, shamt_s;

    assign cur_src1_s  = instruction[SRC1_LSB +: ADDR_W];
    assign cur_src2_s  = instruction[SRC2_LSB +: ADDR_W];
    assign cur_shamt_s = instruction[SHAMT_LSB +: SHAMT_W];
    assign imm_word_s  = WIDTH'(instruction);

    // In S_IMM the held instruction's operands are re-read so that a
    // write-back landing between the two words is observed.
    always_comb begin
        rd1_addr_s = cur_src1_s;
        rd2_addr_s = cur_src2_s;
        if (state_r == S_IMM) begin
            rd1_addr_s = held_src1_r;
            rd2_addr_s = held_src2_r;
        end else begin
            rd1_addr_s = cur_src1_s;
            rd2_addr_s = cur_src2_s;
        end
    end

    param_reg_file #(
        .WIDTH  (WIDTH),
        .N_REGS (N_REGS)
    ) u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rd1_addr_s),
        .raddr2 (rd2_addr_s),
        .rdata1 (rd1_data_s),
        .rdata2 (rd2_data_s)
    );

    // Load-use hazard: a fresh instruction reads the register a load in EX
    // is about to produce.
    always_comb begin
        hazard_s = 1'b0;
        if ((state_r == S_IDLE) && instr_valid && ex_mem_read &&
            ((ex_rd == cur_src1_s) || (ex_rd == cur_src2_s))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // A flush redirects fetch, so it overrides the fetch stall.
    assign stall_fetch = reset & ~flush & (ex_stall | hazard_s);

    // Next-state and ID/EX next-value selection in priority order:
    // flush > ex_stall > hazard > no valid word > normal decode.
    always_comb begin
        state_next_s = state_r;
        held_ctrl_s  = held_ctrl_r;
        held_pc_s    = held_pc_r;
        held_src1_s  = held_src1_r;
        held_src2_s  = held_src2_r;
        held_shamt_s = held_shamt_r;
        idv_s        = 1'b0;
        ctrl_s       = '0;
        s1d_s        = '0;
        s2d_s        = '0;
        s1_s         = '0;
        s2_s         = '0;
        dst_s        = '0;
        pc_s         = '0;
        imm_s        = '0;
        shamt_s      = '0;
        if (flush) begin
            state_next_s = S_IDLE;
            held_ctrl_s  = '0;
            held_pc_s    = '0;
            held_src1_s  = '0;
            held_src2_s  = '0;
            held_shamt_s = '0;
        end else if (ex_stall) begin
            idv_s   = idv_r;
            ctrl_s  = ctrl_r;
            s1d_s   = s1d_r;
            s2d_s   = s2d_r;
            s1_s    = s1_r;
            s2_s    = s2_r;
            dst_s   = dst_r;
            pc_s    = pc_r;
            imm_s   = imm_r;
            shamt_s = shamt_r;
        end else if (hazard_s) begin
            state_next_s = state_r;
        end else if (!instr_valid) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (two_word) begin
                        held_ctrl_s  = ctrl;
                        held_pc_s    = pc;
                        held_src1_s  = cur_src1_s;
                        held_src2_s  = cur_src2_s;
                        held_shamt_s = cur_shamt_s;
                        state_next_s = S_IMM;
                    end else begin
                        idv_s   = 1'b1;
                        ctrl_s  = ctrl;
                        s1d_s   = rd1_data_s;
                        s2d_s   = rd2_data_s;
                        s1_s    = cur_src1_s;
                        s2_s    = cur_src2_s;
                        dst_s   = cur_src1_s;
                        pc_s    = pc;
                        imm_s   = '0;
                        shamt_s = cur_shamt_s;
                    end
                end
                S_IMM: begin
                    idv_s        = 1'b1;
                    ctrl_s       = held_ctrl_r;
                    s1d_s        = rd1_data_s;
                    s2d_s        = rd2_data_s;
                    s1_s         = held_src1_r;
                    s2_s         = held_src2_r;
                    dst_s        = held_src1_r;
                    pc_s         = held_pc_r;
                    imm_s        = imm_word_s;
                    shamt_s      = held_shamt_r;
                    state_next_s = S_IDLE;
                end
                default: begin
                    state_next_s = S_IDLE;
                end
            endcase
        end
    end

    // FSM, held-word and ID/EX registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            held_ctrl_r  <= '0;
            held_pc_r    <= '0;
            held_src1_r  <= '0;
            held_src2_r  <= '0;
            held_shamt_r <= '0;
            idv_r        <= 1'b0;
            ctrl_r       <= '0;
            s1d_r        <= '0;
            s2d_r        <= '0;
            s1_r         <= '0;
            s2_r         <= '0;
            dst_r        <= '0;
            pc_r         <= '0;
            imm_r        <= '0;
            shamt_r      <= '0;
        end else begin
            state_r      <= state_next_s;
            held_ctrl_r  <= held_ctrl_s;
            held_pc_r    <= held_pc_s;
            held_src1_r  <= held_src1_s;
            held_src2_r  <= held_src2_s;
            held_shamt_r <= held_shamt_s;
            idv_r        <= idv_s;
            ctrl_r       <= ctrl_s;
            s1d_r        <= s1d_s;
            s2d_r        <= s2d_s;
            s1_r         <= s1_s;
            s2_r         <= s2_s;
            dst_r        <= dst_s;
            pc_r         <= pc_s;
            imm_r        <= imm_s;
            shamt_r      <= shamt_s;
        end
    end

    assign id_valid     = idv_r;
    assign id_ctrl      = ctrl_r;
    assign id_src1_data = s1d_r;
    assign id_src2_data = s2d_r;
    assign id_src1      = s1_r;
    assign id_src2      = s2_r;
    assign id_dst       = dst_r;
    assign id_pc        = pc_r;
    assign id_imm       = imm_r;
    assign id_shamt     = shamt_r;

endmodule : param_decode_stage

// File: tb/tb_param_decode_stage.sv
// Scoreboard bench for param_decode_stage (default parameters).
// The driver pushes the hand-computed ID/EX contents expected after each
// clock; a monitor pops and compares one entry per clock.
module tb_param_decode_stage;

    typedef struct {
        string       name;
        logic        full;   // 1: compare every field, 0: bubble (valid/ctrl)
        logic        v;
        logic [23:0] ctrl;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [2:0]  dst;
        logic [31:0] pc;
        logic [15:0] imm;
        logic [3:0]  sh;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [31:0] pc;
    logic [23:0] ctrl;
    logic        two_word;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_mem_read;
    logic [2:0]  ex_rd;
    logic        flush;
    logic        ex_stall;
    logic        stall_fetch;
    logic        id_valid;
    logic [23:0] id_ctrl;
    logic [15:0] id_src1_data;
    logic [15:0] id_src2_data;
    logic [2:0]  id_src1;
    logic [2:0]  id_src2;
    logic [2:0]  id_dst;
    logic [31:0] id_pc;
    logic [15:0] id_imm;
    logic [3:0]  id_shamt;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    param_decode_stage dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instruction  (instruction),
        .pc           (pc),
        .ctrl         (ctrl),
        .two_word     (two_word),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .flush        (flush),
        .ex_stall     (ex_stall),
        .stall_fetch  (stall_fetch),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .id_src1_data (id_src1_data),
        .id_src2_data (id_src2_data),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_dst       (id_dst),
        .id_pc        (id_pc),
        .id_imm       (id_imm),
        .id_shamt     (id_shamt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t iss(input logic [23:0] c, input logic [2:0] s1, input logic [15:0] d1,
                                 input logic [2:0] s2, input logic [15:0] d2, input logic [2:0] dst,
                                 input logic [31:0] p, input logic [15:0] imm, input logic [3:0] sh);
        exp_t e;
        e.name = ""; e.full = 1'b1; e.v = 1'b1; e.ctrl = c;
        e.s1 = s1; e.d1 = d1; e.s2 = s2; e.d2 = d2; e.dst = dst;
        e.pc = p; e.imm = imm; e.sh = sh;
        return e;
    endfunction

    function automatic exp_t zero_all();
        exp_t e;
        e = iss(24'h0, 3'd0, 16'h0, 3'd0, 16'h0, 3'd0, 32'h0, 16'h0, 4'h0);
        e.v = 1'b0;
        return e;
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e = zero_all();
        e.full = 1'b0;
        return e;
    endfunction

    task automatic set_in(input logic v, input logic [15:0] ins, input logic [31:0] p,
                          input logic [23:0] c, input logic tw);
        instr_valid = v;
        instruction = ins;
        pc          = p;
        ctrl        = c;
        two_word    = tw;
    endtask

    // Check stall_fetch for the current inputs, queue the expected ID/EX
    // contents for after the next edge, then advance past that edge.
    task automatic tick(input string nm, input logic exp_stall, input exp_t e);
        #1;
        chk({nm, ".stall_fetch"}, 32'(stall_fetch), 32'(exp_stall));
        e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".id_valid"}, 32'(id_valid), 32'(e.v));
                chk({e.name, ".id_ctrl"},  32'(id_ctrl),  32'(e.ctrl));
                if (e.full) begin
                    chk({e.name, ".id_src1"},      32'(id_src1),      32'(e.s1));
                    chk({e.name, ".id_src1_data"}, 32'(id_src1_data), 32'(e.d1));
                    chk({e.name, ".id_src2"},      32'(id_src2),      32'(e.s2));
                    chk({e.name, ".id_src2_data"}, 32'(id_src2_data), 32'(e.d2));
                    chk({e.name, ".id_dst"},       32'(id_dst),       32'(e.dst));
                    chk({e.name, ".id_pc"},        id_pc,             e.pc);
                    chk({e.name, ".id_imm"},       32'(id_imm),       32'(e.imm));
                    chk({e.name, ".id_shamt"},     32'(id_shamt),     32'(e.sh));
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        exp_t e44;
        logic [15:0] byp_exp;
`ifdef DECODE_WB_BYPASS_EN
        byp_exp = 16'hBEEF;
`else
        byp_exp = 16'h1111;
`endif
        reset = 1'b0; flush = 1'b0; ex_stall = 1'b1;
        wb_we = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
        ex_mem_read = 1'b1; ex_rd = 3'd7;
        set_in(1'b1, 16'h0700, 32'h50, 24'hFFFFFF, 1'b0);
        tick("rst0", 1'b0, zero_all());
        tick("rst1", 1'b0, zero_all());

        reset = 1'b1; ex_stall = 1'b0; ex_mem_read = 1'b0; ex_rd = 3'd0;
        set_in(1'b1, 16'h0000, 32'h100, 24'h000001, 1'b0);
        tick("zero", 1'b0, iss(24'h1, 3'd0, 16'h0, 3'd0, 16'h0, 3'd0, 32'h100, 16'h0, 4'h0));

        set_in(1'b0, 16'h0000, 32'h102, 24'h0, 1'b0);
        wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h00AB;
        tick("wb_r3", 1'b0, bub());

        wb_we = 1'b0;
        set_in(1'b1, 16'h0345, 32'h104, 24'h000ABC, 1'b0);
        tick("read_r3", 1'b0, iss(24'hABC, 3'd3, 16'h00AB, 3'd2, 16'h0, 3'd3, 32'h104, 16'h0, 4'h5));

        set_in(1'b1, 16'h0160, 32'h108, 24'h0000C0, 1'b1);
        wb_we = 1'b1; wb_addr = 3'd1; wb_data = 16'h5555;
        tick("tw_first", 1'b0, bub());

        wb_we = 1'b0;
        set_in(1'b1, 16'h1234, 32'h10A, 24'h999999, 1'b0);
        tick("tw_imm", 1'b0, iss(24'hC0, 3'd1, 16'h5555, 3'd3, 16'h00AB, 3'd1, 32'h108, 16'h1234, 4'h0));

        set_in(1'b1, 16'h0040, 32'h10C, 24'h000011, 1'b0);
        ex_mem_read = 1'b1; ex_rd = 3'd2;
        tick("hazard", 1'b1, bub());

        ex_mem_read = 1'b0;
        tick("hazard_go", 1'b0, iss(24'h11, 3'd0, 16'h0, 3'd2, 16'h0, 3'd0, 32'h10C, 16'h0, 4'h0));

        set_in(1'b1, 16'h0200, 32'h110, 24'h000022, 1'b1);
        tick("fl_first", 1'b0, bub());

        flush = 1'b1;
        set_in(1'b1, 16'h0300, 32'h112, 24'h000023, 1'b0);
        tick("flush", 1'b0, bub());

        flush = 1'b0;
        set_in(1'b1, 16'h0300, 32'h114, 24'h000033, 1'b0);
        tick("post_flush", 1'b0, iss(24'h33, 3'd3, 16'h00AB, 3'd0, 16'h0, 3'd3, 32'h114, 16'h0, 4'h0));

        e44 = iss(24'h44, 3'd1, 16'h5555, 3'd0, 16'h0, 3'd1, 32'h118, 16'h0, 4'h0);
        set_in(1'b1, 16'h0100, 32'h118, 24'h000044, 1'b0);
        tick("pre_stall", 1'b0, e44);

        ex_stall = 1'b1;
        set_in(1'b1, 16'h0200, 32'h11C, 24'h000055, 1'b0);
        tick("ex_stall_hold", 1'b1, e44);

        ex_stall = 1'b0;
        tick("stall_go", 1'b0, iss(24'h55, 3'd2, 16'h0, 3'd0, 16'h0, 3'd2, 32'h11C, 16'h0, 4'h0));

        set_in(1'b0, 16'h0000, 32'h11E, 24'h0, 1'b0);
        wb_we = 1'b1; wb_addr = 3'd5; wb_data = 16'h1111;
        tick("wb_r5_old", 1'b0, bub());

        wb_data = 16'hBEEF;
        set_in(1'b1, 16'h0500, 32'h120, 24'h000066, 1'b0);
        tick("bypass_r5", 1'b0, iss(24'h66, 3'd5, byp_exp, 3'd0, 16'h0, 3'd5, 32'h120, 16'h0, 4'h0));

        wb_we = 1'b0;
        set_in(1'b1, 16'h0100, 32'h124, 24'h000070, 1'b1);
        tick("rst_tw_first", 1'b0, bub());

        reset = 1'b0;
        set_in(1'b1, 16'h0300, 32'h126, 24'h000071, 1'b0);
        tick("rst_in_imm", 1'b0, zero_all());

        reset = 1'b1;
        set_in(1'b1, 16'h0300, 32'h130, 24'h000077, 1'b0);
        tick("after_rst", 1'b0, iss(24'h77, 3'd3, 16'h0, 3'd0, 16'h0, 3'd3, 32'h130, 16'h0, 4'h0));

        set_in(1'b0, 16'h0000, 32'h0, 24'h0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_param_decode_stage
